// File: rtl/fsm_engine_arbiter.sv
// Round-robin arbiter that lends one shared behaviour FSM engine to NUM_REQ agents,
// holding each grant until the engine reports STOP or a watchdog aborts the job.
module fsm_engine_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int SENSOR_W    = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*SENSOR_W-1:0]  sensor_bus,
    output logic [NUM_REQ-1:0]           grant,
    output logic [NUM_REQ-1:0]           done,
    output logic                         timeout_err,
    output logic                         busy,
    output logic [SENSOR_W-1:0]          eng_sensor,
    output logic                         eng_rst,
    input  logic [2:0]                   eng_action
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYC);

    localparam logic [2:0]       ACT_STOP = 3'b100;
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_ARB,
        ST_RUN,
        ST_ABORT
    } state_t;

    state_t               r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   r_done;
    logic                 r_timeout_err;
    logic [IDX_W-1:0]     r_last;
    logic [WD_W-1:0]      r_wdog;

    logic [IDX_W-1:0]     w_cand;
    logic [IDX_W-1:0]     w_win_idx;
    logic                 w_win_valid;
    logic [SENSOR_W-1:0]  w_eng_sensor;

    // Rotating priority: the scan starts one past the last winner and wraps.
    // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
    always_comb begin
        w_cand      = r_last;
        w_win_idx   = '0;
        w_win_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = (w_cand == IDX_LAST) ? '0 : w_cand + 1'b1;
            if (!w_win_valid && req[w_cand]) begin
                w_win_valid = 1'b1;
                w_win_idx   = w_cand;
            end
        end
    end

    // Engine input is driven only while a job runs, so the engine idles between jobs.
    always_comb begin
        w_eng_sensor = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_state == ST_RUN && r_grant[i]) begin
                w_eng_sensor = sensor_bus[i*SENSOR_W +: SENSOR_W];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_ARB;
            r_grant       <= '0;
            r_done        <= '0;
            r_timeout_err <= 1'b0;
            r_last        <= IDX_LAST;
            r_wdog        <= '0;
        end else begin
            r_done        <= '0;
            r_timeout_err <= 1'b0;
            case (r_state)
                ST_ARB: begin
                    if (w_win_valid) begin
                        r_grant <= NUM_REQ'(1) << w_win_idx;
                        r_last  <= w_win_idx;
                        r_wdog  <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // STOP takes precedence over a watchdog expiring on the same edge.
                    if (eng_action == ACT_STOP) begin
                        r_grant <= '0;
                        r_done  <= r_grant;
                        r_state <= ST_ARB;
                    end else if (r_wdog == WD_LAST) begin
                        r_grant       <= '0;
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_ABORT;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                ST_ABORT: r_state <= ST_ARB;
                default:  r_state <= ST_ARB;
            endcase
        end
    end

    assign grant       = r_grant;
    assign done        = r_done;
    assign timeout_err = r_timeout_err;
    assign busy        = (r_state != ST_ARB);
    assign eng_sensor  = w_eng_sensor;
    // The abort pulse doubles as the engine reset; r_timeout_err is high exactly during ABORT.
    assign eng_rst     = rst | r_timeout_err;

    a_grant_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(r_grant));
    a_done_xor_err : assert property (@(posedge clk) disable iff (rst) !((|r_done) && r_timeout_err));

endmodule

// File: tb/tb_fsm_engine_arbiter.sv
// Directed-vector bench for fsm_engine_arbiter: a vector table for reset and a single
// job, then hand-written sequences for rotation, non-preemption, watchdog and reset.
module tb_fsm_engine_arbiter;

    localparam int NR = 4;
    localparam int SW = 4;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req = '0;
    logic [NR*SW-1:0]  sensor_bus = '0;
    logic [NR-1:0]     grant;
    logic [NR-1:0]     done;
    logic              timeout_err;
    logic              busy;
    logic [SW-1:0]     eng_sensor;
    logic              eng_rst;
    logic [2:0]        eng_action = 3'b000;

    always #5 clk = ~clk;

    fsm_engine_arbiter #(
        .NUM_REQ    (NR),
        .SENSOR_W   (SW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .sensor_bus (sensor_bus),
        .grant      (grant),
        .done       (done),
        .timeout_err(timeout_err),
        .busy       (busy),
        .eng_sensor (eng_sensor),
        .eng_rst    (eng_rst),
        .eng_action (eng_action)
    );

    typedef struct {
        logic          rst;
        logic [NR-1:0] req;
        logic [15:0]   sbus;
        logic [2:0]    act;
        logic [NR-1:0] grant;
        logic [NR-1:0] done;
        logic          terr;
        logic          busy;
        logic          erst;
        logic [SW-1:0] esens;
    } vec_t;

    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [15:0] sb,
                                input logic [2:0] a, input logic [3:0] g, input logic [3:0] d,
                                input logic te, input logic bz, input logic er, input logic [3:0] es);
        vec_t v;
        v.rst = r;  v.req = rq;  v.sbus = sb;  v.act = a;
        v.grant = g; v.done = d; v.terr = te;  v.busy = bz; v.erst = er; v.esens = es;
        return v;
    endfunction

    // Inputs change on the falling edge; outputs are compared 1 time unit later,
    // i.e. they reflect the preceding rising edge plus the current inputs.
    task automatic step(input string name, input vec_t v);
        @(negedge clk);
        rst        = v.rst;
        req        = v.req;
        sensor_bus = v.sbus;
        eng_action = v.act;
        #1;
        checks++;
        if ({grant, done, timeout_err, busy, eng_rst, eng_sensor} !==
            {v.grant, v.done, v.terr, v.busy, v.erst, v.esens}) begin
            errors++;
            $display("FAIL %s: got grant=%b done=%b terr=%b busy=%b eng_rst=%b eng_sensor=%b; want grant=%b done=%b terr=%b busy=%b eng_rst=%b eng_sensor=%b",
                     name, grant, done, timeout_err, busy, eng_rst, eng_sensor,
                     v.grant, v.done, v.terr, v.busy, v.erst, v.esens);
        end
    endtask

    localparam logic [15:0] SB = 16'h8421;  // agent i presents sensor 1<<i

    initial begin
        vec_t tbl[$];
        logic [3:0] exp_g;
        logic [3:0] exp_d;

        // rst, req, sbus, act | grant, done, terr, busy, eng_rst, eng_sensor
        tbl.push_back(mk(1, 4'b0000, 16'h0000, 3'b000, 4'b0000, 4'b0000, 0, 0, 1, 4'b0000));
        tbl.push_back(mk(0, 4'b0001, 16'h0001, 3'b000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 4'b0001, 16'h0001, 3'b000, 4'b0001, 4'b0000, 0, 1, 0, 4'b0001));
        tbl.push_back(mk(0, 4'b0001, 16'h0002, 3'b001, 4'b0001, 4'b0000, 0, 1, 0, 4'b0010));
        tbl.push_back(mk(0, 4'b0001, 16'h0004, 3'b010, 4'b0001, 4'b0000, 0, 1, 0, 4'b0100));
        tbl.push_back(mk(0, 4'b0001, 16'h0004, 3'b100, 4'b0001, 4'b0000, 0, 1, 0, 4'b0100));
        tbl.push_back(mk(0, 4'b0000, 16'h0000, 3'b000, 4'b0000, 4'b0001, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 16'h0000, 3'b000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, 16'h0000, 3'b000, 4'b0000, 4'b0000, 0, 0, 1, 4'b0000));

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("tbl[%0d]", i), tbl[i]);
        end

        // Round-robin with all requests held: each job stops on its first RUN cycle.
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            exp_d = (k == 0) ? 4'b0000 : (4'b0001 << ((k - 1) % 4));
            step($sformatf("rr_arb[%0d]", k), mk(0, 4'b1111, SB, 3'b000, 4'b0000, exp_d, 0, 0, 0, 4'b0000));
            step($sformatf("rr_run[%0d]", k), mk(0, 4'b1111, SB, 3'b100, exp_g, 4'b0000, 0, 1, 0, exp_g));
        end

        // Non-preemption: agent 2 keeps the engine while req[0] rises and req[2] drops.
        step("np_arb",   mk(0, 4'b0100, SB, 3'b000, 4'b0000, 4'b0001, 0, 0, 0, 4'b0000));
        step("np_run0",  mk(0, 4'b0101, SB, 3'b000, 4'b0100, 4'b0000, 0, 1, 0, 4'b0100));
        step("np_run1",  mk(0, 4'b0001, SB, 3'b001, 4'b0100, 4'b0000, 0, 1, 0, 4'b0100));
        step("np_stop",  mk(0, 4'b1001, SB, 3'b100, 4'b0100, 4'b0000, 0, 1, 0, 4'b0100));
        step("np_done",  mk(0, 4'b1001, SB, 3'b000, 4'b0000, 4'b0100, 0, 0, 0, 4'b0000));
        step("np_next",  mk(0, 4'b1001, SB, 3'b100, 4'b1000, 4'b0000, 0, 1, 0, 4'b1000));

        // Watchdog: agent 1 presents 0000, the engine never reaches STOP.
        step("wd_arb",   mk(0, 4'b0010, 16'h8401, 3'b000, 4'b0000, 4'b1000, 0, 0, 0, 4'b0000));
        for (int c = 0; c < TO; c++) begin
            step($sformatf("wd_run[%0d]", c), mk(0, 4'b0010, 16'h8401, 3'b000, 4'b0010, 4'b0000, 0, 1, 0, 4'b0000));
        end
        step("wd_abort", mk(0, 4'b0000, 16'h8401, 3'b000, 4'b0000, 4'b0000, 1, 1, 1, 4'b0000));
        step("wd_idle",  mk(0, 4'b0000, 16'h8401, 3'b000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000));

        // STOP on the watchdog terminal cycle; rotation resumes after agent 1.
        step("ts_arb",   mk(0, 4'b1111, SB, 3'b000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000));
        for (int c = 0; c < TO - 1; c++) begin
            step($sformatf("ts_run[%0d]", c), mk(0, 4'b1111, SB, 3'b000, 4'b0100, 4'b0000, 0, 1, 0, 4'b0100));
        end
        step("ts_stop",  mk(0, 4'b1111, SB, 3'b100, 4'b0100, 4'b0000, 0, 1, 0, 4'b0100));
        step("ts_done",  mk(0, 4'b0000, SB, 3'b000, 4'b0000, 4'b0100, 0, 0, 0, 4'b0000));

        // Asynchronous reset while agent 1 holds the engine, with STOP pending.
        step("rs_arb",   mk(0, 4'b0010, SB, 3'b000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000));
        step("rs_run",   mk(0, 4'b0010, SB, 3'b000, 4'b0010, 4'b0000, 0, 1, 0, 4'b0010));
        step("rs_assert",mk(1, 4'b0010, SB, 3'b100, 4'b0000, 4'b0000, 0, 0, 1, 4'b0000));
        step("rs_hold",  mk(1, 4'b1111, SB, 3'b000, 4'b0000, 4'b0000, 0, 0, 1, 4'b0000));
        step("rs_rel",   mk(0, 4'b1111, SB, 3'b000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000));
        step("rs_grant", mk(0, 4'b1111, SB, 3'b000, 4'b0001, 4'b0000, 0, 1, 0, 4'b0001));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsm_engine_arbiter.md
Name: fsm_engine_arbiter

Overview:
- Shares one behaviour FSM engine (4-bit sensor input; 3-bit one-hot action output: IDLE=000, WALK=001, TURN=010, STOP=100) among NUM_REQ requesting agents.
- Grants round-robin and routes the winner's sensor vector to the engine.
- Holds the grant until the engine reports STOP. Aborts and resets the engine through a watchdog if STOP never arrives.
- Sits between the agent layer and the engine in the SoC control subsystem.

Parameters:
- NUM_REQ, 4: number of requesters; 2..8.
- SENSOR_W, 4: sensor vector width per requester; equals the engine input width.
- TIMEOUT_CYC, 64: maximum RUN cycles before abort; at least 4. Counter width is clog2(TIMEOUT_CYC).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NUM_REQ  level request per agent.
- sensor_bus  in  NUM_REQ*SENSOR_W  agent i's sensors at bits [i*SENSOR_W +: SENSOR_W].
- grant  out  NUM_REQ  one-hot or zero; registered.
- done  out  NUM_REQ  one-cycle pulse to the agent whose job reached STOP.
- timeout_err  out  1  one-cycle pulse on watchdog abort.
- busy  out  1  high while state is RUN or ABORT.
- eng_sensor  out  SENSOR_W  to engine sensor_in.
- eng_rst  out  1  to engine rst.
- eng_action  in  3  from engine action_out.

Behaviour:
- Reset (async): state=ARB; grant=0, done=0, timeout_err=0, wdog=0; rr pointer last=NUM_REQ-1, so req[0] has top priority first.
- eng_rst = rst OR abort_pulse. This passes reset through to the engine combinationally.
- States:
  - ARB, RUN, ABORT.
  - No DONE state: completion is handled by registered outputs on the RUN->ARB edge.
- ARB:
  - Scan req starting at last+1, wrapping modulo NUM_REQ. The first set bit wins.
  - At the next edge: grant=onehot(winner), last=winner, wdog=0, state=RUN.
  - If req==0, stay in ARB with grant=0.
  - Latency from req rising to grant is 1 cycle.
- RUN:
  - eng_sensor = sensor_bus slice of the granted index (combinational mux from registered grant).
  - wdog increments each RUN cycle.
  - Grant is non-preemptive: dropping req or a higher-priority request does not change grant.
- RUN, completion:
  - If eng_action==3'b100 is sampled at an edge, then in the next cycle: grant=0, done[idx]=1 for exactly one cycle, state=ARB.
  - The engine self-returns to IDLE after STOP.
- RUN, timeout:
  - If eng_action!=100 and wdog==TIMEOUT_CYC-1, then in the next cycle: state=ABORT, grant=0, timeout_err=1, eng_rst=1. done stays 0.
  - ABORT lasts exactly 1 cycle, then ARB.
- Simultaneous STOP and wdog terminal in the same cycle: STOP wins. done pulses; no timeout_err.
- Outside RUN, eng_sensor=0. This guarantees the engine idles between jobs.
- The last pointer updates only on a grant. After completion or abort, the arbiter resumes the rotation from last+1.
- Back-to-back traffic:
  - A new grant can appear 1 cycle after done: done cycle in ARB, grant on the following edge.
  - Minimum gap is 1 cycle with grant=0.
- Reset mid-RUN: all outputs clear immediately; any pending done or timeout is lost; the engine is held in reset.
- Invariants: grant is always one-hot or zero; done and timeout_err are never high together.

Test Plan:
- Single job, NUM_REQ=4:
  - Stimulus: req=0001. Agent 0 drives sensor 0001, then 0010, then 0100.
  - Response: grant=0001 1 cycle after req. Engine walks IDLE->WALK->TURN->STOP.
  - Response: done=0001 one cycle after action 100, with grant=0000 in the same cycle.
- Round-robin:
  - Stimulus: req=1111 held; every job completes.
  - Response: grant sequence 0001, 0010, 0100, 1000, 0001. No grant is repeated before all others are served.
- Non-preemption:
  - Stimulus: agent 2 granted; req[0] rises mid-job; agent 2 drops req.
  - Response: grant stays 0100 until STOP. The next grant is 1000 if req[3] is set, else 0001.
- Watchdog, TIMEOUT_CYC=8:
  - Stimulus: granted agent holds sensor 0000, so the engine stays IDLE.
  - Response: 8 RUN cycles, then timeout_err=1 and eng_rst=1 for 1 cycle, grant=0, done=0. Then ARB.
- STOP on the terminal cycle:
  - Stimulus: action 100 sampled in the same cycle that wdog==TIMEOUT_CYC-1.
  - Response: done pulses; timeout_err stays 0.
- Async reset mid-RUN:
  - Stimulus: rst pulsed while grant=0010.
  - Response: grant, done and timeout_err are 0 immediately; eng_rst=1 while rst is high. After release, req=1111 yields grant=0001.
